// File: rtl/pong_video_pkg.sv
// Shared video types and constants for the pong pixel path.
// Pure declarations: no latency, no backpressure.
package pong_video_pkg;

  localparam int COLOR_W = 12;

  typedef logic [COLOR_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    FLASH_ON,
    FLASH_OFF
  } flash_state_t;

  localparam rgb_t RGB_BLACK = 12'h000;
  localparam rgb_t RGB_WHITE = 12'hFFF;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flash_sequencer.sv
// Frame-counted background flash FSM (built only with PIXEL_ARB_FLASH_EN).
// Outputs registered, react one clock after tick/score; no backpressure.
module flash_sequencer
  import pong_video_pkg::*;
#(
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_COUNT  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic score_pulse,
  output logic flash_on,
  output logic flash_active
);

  localparam int FW = cnt_w(FLASH_FRAMES);
  localparam int PW = cnt_w(FLASH_COUNT);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [PW-1:0] PAIR_LAST  = PW'(FLASH_COUNT - 1);

  flash_state_t    r_state;
  logic [FW-1:0]   r_frame_cnt;
  logic [PW-1:0]   r_pair_cnt;
  logic            r_on;
  logic            r_active;

  // A score pulse always restarts the sequence, swallowing a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_pair_cnt  <= '0;
      r_on        <= 1'b0;
      r_active    <= 1'b0;
    end else if (score_pulse) begin
      r_state     <= FLASH_ON;
      r_frame_cnt <= '0;
      r_pair_cnt  <= '0;
      r_on        <= 1'b1;
      r_active    <= 1'b1;
    end else begin
      case (r_state)
        FLASH_ON: begin
          if (frame_tick) begin
            if (r_frame_cnt == FRAME_LAST) begin
              r_state     <= FLASH_OFF;
              r_frame_cnt <= '0;
              r_on        <= 1'b0;
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        FLASH_OFF: begin
          if (frame_tick) begin
            if (r_frame_cnt == FRAME_LAST) begin
              r_frame_cnt <= '0;
              if (r_pair_cnt == PAIR_LAST) begin
                r_state  <= IDLE;
                r_active <= 1'b0;
              end else begin
                r_pair_cnt <= r_pair_cnt + 1'b1;
                r_state    <= FLASH_ON;
                r_on       <= 1'b1;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_on     <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign flash_on     = r_on;
  assign flash_active = r_active;

endmodule

// File: rtl/pixel_layer_arbiter.sv
// Fixed-priority pixel layer mux with optional score flash (PIXEL_ARB_FLASH_EN).
// Latency 2 clk from inputs to rgb/layer_sel; no backpressure, one pixel per cycle.
module pixel_layer_arbiter
  import pong_video_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = pong_video_pkg::COLOR_W,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_COUNT  = 3,
  localparam int SEL_W       = $clog2(NUM_LAYERS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          video_on,
  input  logic                          frame_tick,
  input  logic [NUM_LAYERS-1:0]         layer_req,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [COLOR_W-1:0]            bg_rgb,
  input  logic [COLOR_W-1:0]            flash_rgb,
  input  logic                          score_pulse,
  output logic [COLOR_W-1:0]            rgb,
  output logic [SEL_W-1:0]              layer_sel,
  output logic                          flash_active
);

  localparam logic [SEL_W-1:0] SEL_BG = SEL_W'(NUM_LAYERS);

  logic [SEL_W-1:0]   w_win_sel;
  logic [COLOR_W-1:0] w_win_rgb;
  logic [COLOR_W-1:0] w_bg_rgb;
  logic               w_flash_on;

  logic               r_s1_vld;
  logic               r_s1_vid;
  logic [SEL_W-1:0]   r_s1_sel;
  logic [COLOR_W-1:0] r_s1_rgb;
  logic [COLOR_W-1:0] r_rgb;
  logic [SEL_W-1:0]   r_sel;

  // Walk from lowest priority up so the lowest requesting index wins.
  always_comb begin
    w_win_sel = SEL_BG;
    w_win_rgb = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_req[i]) begin
        w_win_sel = SEL_W'(i);
        w_win_rgb = layer_rgb[i*COLOR_W +: COLOR_W];
      end
    end
  end

`ifdef PIXEL_ARB_FLASH_EN
  flash_sequencer #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_COUNT  (FLASH_COUNT)
  ) u_flash_sequencer (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .score_pulse  (score_pulse),
    .flash_on     (w_flash_on),
    .flash_active (flash_active)
  );
`else
  // Flash inputs have no consumer in this build; fold them into a sink.
  logic w_unused_flash;
  assign w_unused_flash = ^{frame_tick, score_pulse, flash_rgb};
  assign w_flash_on     = 1'b0;
  assign flash_active   = 1'b0;
`endif

  assign w_bg_rgb = w_flash_on ? flash_rgb : bg_rgb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
      r_s1_vid <= 1'b0;
      r_s1_sel <= SEL_BG;
      r_s1_rgb <= '0;
    end else begin
      r_s1_vld <= 1'b1;
      r_s1_vid <= video_on;
      r_s1_sel <= w_win_sel;
      r_s1_rgb <= w_win_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !r_s1_vld) begin
      r_rgb <= '0;
      r_sel <= SEL_BG;
    end else begin
      r_sel <= r_s1_sel;
      if (!r_s1_vid)
        r_rgb <= '0;
      else if (r_s1_sel != SEL_BG)
        r_rgb <= r_s1_rgb;
      else
        r_rgb <= w_bg_rgb;
    end
  end

  assign rgb       = r_rgb;
  assign layer_sel = r_sel;

endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// Randomised scoreboard bench for pixel_layer_arbiter with FLASH_FRAMES=2, FLASH_COUNT=2.
// Flash expectations apply only when PIXEL_ARB_FLASH_EN is defined.
module tb_pixel_layer_arbiter;

  localparam int NL = 4;
  localparam int CW = 12;
  localparam int FF = 2;
  localparam int FC = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            video_on = 1'b0;
  logic            frame_tick = 1'b0;
  logic [NL-1:0]   layer_req = '0;
  logic [NL*CW-1:0] layer_rgb = '0;
  logic [CW-1:0]   bg_rgb = '0;
  logic [CW-1:0]   flash_rgb = '0;
  logic            score_pulse = 1'b0;
  logic [CW-1:0]   rgb;
  logic [2:0]      layer_sel;
  logic            flash_active;

  always #5 clk = ~clk;

  pixel_layer_arbiter #(
    .NUM_LAYERS   (NL),
    .COLOR_W      (CW),
    .FLASH_FRAMES (FF),
    .FLASH_COUNT  (FC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .video_on     (video_on),
    .frame_tick   (frame_tick),
    .layer_req    (layer_req),
    .layer_rgb    (layer_rgb),
    .bg_rgb       (bg_rgb),
    .flash_rgb    (flash_rgb),
    .score_pulse  (score_pulse),
    .rgb          (rgb),
    .layer_sel    (layer_sel),
    .flash_active (flash_active)
  );

  typedef struct packed {
    logic [CW-1:0] rgb;
    logic [2:0]    sel;
  } pix_t;

  pix_t pix_q[$];
  bit   act_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: flash position is "ticks since the score event".
  bit            m_active = 0;
  int            m_ticks = 0;
  logic [CW-1:0] m_bg = '0;
  logic [CW-1:0] m_fl = '0;

  task automatic drive(input bit rst, input bit vid, input logic [NL-1:0] req,
                       input logic [NL*CW-1:0] lrgb, input bit sp, input bit ft);
    pix_t e;
    bit   on;
    int   win;
    @(posedge clk);
    #2;
    reset = rst; video_on = vid; layer_req = req; layer_rgb = lrgb;
    score_pulse = sp; frame_tick = ft; bg_rgb = m_bg; flash_rgb = m_fl;
    if (rst) begin
      m_active = 0;
      m_ticks  = 0;
      e.rgb = '0;
      e.sel = 3'(NL);
      if (pix_q.size() > 0) pix_q[pix_q.size()-1] = e;
    end else begin
      if (sp) begin
        m_active = 1;
        m_ticks  = 0;
      end else if (m_active && ft) begin
        m_ticks++;
        if (m_ticks == 2 * FF * FC) m_active = 0;
      end
`ifdef PIXEL_ARB_FLASH_EN
      on = m_active && (((m_ticks / FF) % 2) == 0);
`else
      on = 0;
`endif
      win = NL;
      for (int i = 0; i < NL; i++)
        if (req[i] && win == NL) win = i;
      e.sel = 3'(win);
      if (!vid)         e.rgb = '0;
      else if (win < NL) e.rgb = lrgb[win*CW +: CW];
      else              e.rgb = on ? m_fl : m_bg;
    end
    pix_q.push_back(e);
`ifdef PIXEL_ARB_FLASH_EN
    act_q.push_back(m_active);
`else
    act_q.push_back(1'b0);
`endif
  endtask

  // Colours only change after a blanked pixel, so stage-2 sampling timing is moot.
  task automatic set_colours(input logic [CW-1:0] b, input logic [CW-1:0] f);
    drive(0, 0, '0, '0, 0, 0);
    m_bg = b;
    m_fl = f;
  endtask

  task automatic rand_pix(input bit sp, input bit ft);
    logic [63:0] r64;
    logic [NL-1:0] req;
    r64 = {$urandom, $urandom};
    req = NL'($urandom & $urandom);
    drive(0, ($urandom % 8) != 0, req, r64[NL*CW-1:0], sp, ft);
  endtask

  task automatic bg_tick(input bit sp, input bit ft);
    drive(0, 1, '0, '0, sp, ft);
    for (int j = 0; j < 3; j++) drive(0, 1, '0, '0, 0, 0);
  endtask

  always begin
    pix_t e;
    bit   ea;
    @(posedge clk);
    #1;
    if (act_q.size() > 0) begin
      ea = act_q.pop_front();
      total++;
      if (flash_active !== ea) begin
        bad++;
        $display("FAIL flash_active t=%0t got=%b exp=%b", $time, flash_active, ea);
      end
    end
    if (pix_q.size() >= 2) begin
      e = pix_q.pop_front();
      total++;
      if (rgb !== e.rgb || layer_sel !== e.sel) begin
        bad++;
        $display("FAIL pixel t=%0t got rgb=%h sel=%0d exp rgb=%h sel=%0d",
                 $time, rgb, layer_sel, e.rgb, e.sel);
      end
    end
  end

  initial begin
    logic [NL*CW-1:0] lr;
    drive(1, 0, '0, '0, 0, 0);
    drive(1, 0, '0, '0, 0, 0);
    // Background only, then priority picks.
    set_colours(12'h00F, 12'hFFF);
    for (int i = 0; i < 3; i++) drive(0, 1, '0, '0, 0, 0);
    lr = {12'h0F0, 12'h000, 12'hF00, 12'h000};
    drive(0, 1, 4'b1010, lr, 0, 0);
    drive(0, 1, 4'b1000, lr, 0, 0);
    lr = {12'h0F0, 12'h000, 12'hF00, 12'hFFF};
    drive(0, 0, 4'b0001, lr, 0, 0);
    drive(0, 1, 4'b1111, lr, 0, 0);
    // Single flash sequence over 8 ticks.
    set_colours(12'h000, 12'hFFF);
    bg_tick(1, 0);
    for (int t = 0; t < 8; t++) bg_tick(0, 1);
    // Restart in FLASH_OFF with a coincident tick.
    bg_tick(1, 0);
    for (int t = 0; t < FF; t++) bg_tick(0, 1);
    bg_tick(1, 1);
    for (int t = 0; t < 9; t++) bg_tick(0, 1);
    // Reset mid-FLASH_ON, then a fresh sequence.
    bg_tick(1, 0);
    bg_tick(0, 1);
    drive(1, 1, '0, '0, 0, 0);
    bg_tick(0, 0);
    bg_tick(1, 0);
    for (int t = 0; t < 8; t++) bg_tick(0, 1);
    // Random traffic with sparse ticks, scores and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 300 == 0)
        set_colours(CW'($urandom), CW'($urandom));
      else if ($urandom % 600 == 0)
        drive(1, 1, '0, '0, 0, 0);
      else
        rand_pix($urandom % 150 == 0, $urandom % 15 == 0);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, '0, '0, 0, 0);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
